// File: rtl/qr_pkg.sv
// Shared constants and helpers for the ARX quarter-round datapath.
package qr_pkg;

    typedef enum logic {
        QR_MODE_CHACHA = 1'b0,
        QR_MODE_SALSA  = 1'b1
    } qr_mode_e;

    localparam int unsigned QR_MAX_WIDTH = 64;
    localparam int unsigned QR_CHACHA_ROT [4] = '{16, 12, 8, 7};
    localparam int unsigned QR_SALSA_ROT  [4] = '{7, 9, 13, 18};

    // Left rotate within the low w bits; with constant w and r this reduces to wiring.
    function automatic logic [QR_MAX_WIDTH-1:0] rotl(input logic [QR_MAX_WIDTH-1:0] x,
                                                     input int unsigned w,
                                                     input int unsigned r);
        logic [QR_MAX_WIDTH-1:0] m;
        logic [QR_MAX_WIDTH-1:0] v;
        m = (w >= QR_MAX_WIDTH) ? '1 : ((QR_MAX_WIDTH'(1) << w) - QR_MAX_WIDTH'(1));
        v = x & m;
        return ((v << r) | (v >> (w - r))) & m;
    endfunction

endpackage

// File: rtl/qr_step.sv
// One combinational ARX step of the ChaCha or Salsa20 quarter round.
module qr_step
    import qr_pkg::*;
#(
    parameter int unsigned STEP       = 0,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROT_CHACHA = 16,
    parameter int unsigned ROT_SALSA  = 7
) (
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] a_next,
    output logic [DATA_WIDTH-1:0] b_next,
    output logic [DATA_WIDTH-1:0] c_next,
    output logic [DATA_WIDTH-1:0] d_next
);

    function automatic logic [DATA_WIDTH-1:0] rot(input logic [DATA_WIDTH-1:0] x,
                                                  input int unsigned r);
        return DATA_WIDTH'(rotl(QR_MAX_WIDTH'(x), DATA_WIDTH, r));
    endfunction

    always_comb begin
        a_next = a;
        b_next = b;
        c_next = c;
        d_next = d;
        case (STEP)
            0: if (mode == QR_MODE_CHACHA) begin
                a_next = a + b;
                d_next = rot(d ^ (a + b), ROT_CHACHA);
            end else begin
                b_next = b ^ rot(a + d, ROT_SALSA);
            end
            1: if (mode == QR_MODE_CHACHA) begin
                c_next = c + d;
                b_next = rot(b ^ (c + d), ROT_CHACHA);
            end else begin
                c_next = c ^ rot(b + a, ROT_SALSA);
            end
            2: if (mode == QR_MODE_CHACHA) begin
                a_next = a + b;
                d_next = rot(d ^ (a + b), ROT_CHACHA);
            end else begin
                d_next = d ^ rot(c + b, ROT_SALSA);
            end
            3: if (mode == QR_MODE_CHACHA) begin
                c_next = c + d;
                b_next = rot(b ^ (c + d), ROT_CHACHA);
            end else begin
                a_next = a ^ rot(d + c, ROT_SALSA);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/quarter_round_pipe.sv
// Fully pipelined ChaCha/Salsa20 quarter round with per-beat mode and tag.
module quarter_round_pipe
    import qr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter logic [3:0]  REG_MASK       = 4'b1111,
    parameter int unsigned CHACHA_ROT [4] = QR_CHACHA_ROT,
    parameter int unsigned SALSA_ROT  [4] = QR_SALSA_ROT
) (
    input  logic                  i_aclk,
    input  logic                  i_aresetn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_mode,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_c,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [DATA_WIDTH-1:0] o_c,
    output logic [DATA_WIDTH-1:0] o_d,
    output logic                  o_busy
);

    logic                  en;
    logic                  tail_vld;
    logic [TAG_WIDTH-1:0]  tail_tag;
    logic [DATA_WIDTH-1:0] tail_a, tail_b, tail_c, tail_d;

    // Single global advance: the whole pipe moves or the whole pipe holds.
    assign en      = !o_valid | i_ready;
    assign o_ready = en;

    // Each iteration holds the beat entering step k, optionally registered after step k-1.
    for (genvar k = 0; k < 4; k++) begin : g_stage
        localparam bit HAS_REG = (k > 0) && REG_MASK[(k > 0) ? k - 1 : 0];

        logic                  vld;
        logic                  mode;
        logic                  busy;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] a, b, c, d;
        logic [DATA_WIDTH-1:0] a_next, b_next, c_next, d_next;

        if (k == 0) begin : g_src
            assign vld  = i_valid;
            assign mode = i_mode;
            assign tag  = i_tag;
            assign a    = i_a;
            assign b    = i_b;
            assign c    = i_c;
            assign d    = i_d;
            assign busy = 1'b0;
        end else if (HAS_REG) begin : g_reg
            always_ff @(posedge i_aclk) begin
                if (!i_aresetn) begin
                    vld <= 1'b0;
                end else if (en) begin
                    vld <= g_stage[k-1].vld;
                end
            end
            always_ff @(posedge i_aclk) begin
                if (en) begin
                    mode <= g_stage[k-1].mode;
                    tag  <= g_stage[k-1].tag;
                    a    <= g_stage[k-1].a_next;
                    b    <= g_stage[k-1].b_next;
                    c    <= g_stage[k-1].c_next;
                    d    <= g_stage[k-1].d_next;
                end
            end
            assign busy = g_stage[k-1].busy | vld;
        end else begin : g_wire
            assign vld  = g_stage[k-1].vld;
            assign mode = g_stage[k-1].mode;
            assign tag  = g_stage[k-1].tag;
            assign a    = g_stage[k-1].a_next;
            assign b    = g_stage[k-1].b_next;
            assign c    = g_stage[k-1].c_next;
            assign d    = g_stage[k-1].d_next;
            assign busy = g_stage[k-1].busy;
        end

        qr_step #(
            .STEP       (k),
            .DATA_WIDTH (DATA_WIDTH),
            .ROT_CHACHA (CHACHA_ROT[k]),
            .ROT_SALSA  (SALSA_ROT[k])
        ) u_step (
            .mode   (mode),
            .a      (a),
            .b      (b),
            .c      (c),
            .d      (d),
            .a_next (a_next),
            .b_next (b_next),
            .c_next (c_next),
            .d_next (d_next)
        );
    end

    // Optional register after the last step; mode is no longer needed past here.
    if (REG_MASK[3]) begin : g_tail_reg
        always_ff @(posedge i_aclk) begin
            if (!i_aresetn) begin
                tail_vld <= 1'b0;
            end else if (en) begin
                tail_vld <= g_stage[3].vld;
            end
        end
        always_ff @(posedge i_aclk) begin
            if (en) begin
                tail_tag <= g_stage[3].tag;
                tail_a   <= g_stage[3].a_next;
                tail_b   <= g_stage[3].b_next;
                tail_c   <= g_stage[3].c_next;
                tail_d   <= g_stage[3].d_next;
            end
        end
    end else begin : g_tail_wire
        assign tail_vld = g_stage[3].vld;
        assign tail_tag = g_stage[3].tag;
        assign tail_a   = g_stage[3].a_next;
        assign tail_b   = g_stage[3].b_next;
        assign tail_c   = g_stage[3].c_next;
        assign tail_d   = g_stage[3].d_next;
    end

    // Output register, always present and fully reset.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            o_valid <= 1'b0;
            o_tag   <= '0;
            o_a     <= '0;
            o_b     <= '0;
            o_c     <= '0;
            o_d     <= '0;
        end else if (en) begin
            o_valid <= tail_vld;
            o_tag   <= tail_tag;
            o_a     <= tail_a;
            o_b     <= tail_b;
            o_c     <= tail_c;
            o_d     <= tail_d;
        end
    end

    assign o_busy = o_valid | g_stage[3].busy | (REG_MASK[3] ? tail_vld : 1'b0);

endmodule

// File: tb/tb_quarter_round_pipe.sv
// Randomized bench for quarter_round_pipe at three register masks, scored against a reference model.
module tb_quarter_round_pipe;

    localparam int NDUT = 3;
    localparam logic [3:0] MASKS [NDUT] = '{4'b0000, 4'b0101, 4'b1111};

    typedef struct {
        logic        mode;
        logic [3:0]  tag;
        logic [31:0] a, b, c, d;
        int          cyc;
    } beat_t;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        i_mode  = 1'b0;
    logic [3:0]  i_tag   = '0;
    logic [31:0] i_a = '0, i_b = '0, i_c = '0, i_d = '0;

    logic        o_ready [NDUT];
    logic        o_valid [NDUT];
    logic        o_busy  [NDUT];
    logic [3:0]  o_tag   [NDUT];
    logic [31:0] o_a [NDUT], o_b [NDUT], o_c [NDUT], o_d [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    bit lat_chk  = 1'b0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cycle <= cycle + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int r);
        return (x << r) | (x >> (32 - r));
    endfunction

    // Quarter round straight from the algorithm description.
    function automatic beat_t qr_model(input beat_t x);
        beat_t y = x;
        if (x.mode == 1'b0) begin
            y.a = y.a + y.b; y.d = rl(y.d ^ y.a, 16);
            y.c = y.c + y.d; y.b = rl(y.b ^ y.c, 12);
            y.a = y.a + y.b; y.d = rl(y.d ^ y.a, 8);
            y.c = y.c + y.d; y.b = rl(y.b ^ y.c, 7);
        end else begin
            y.b = y.b ^ rl(y.a + y.d, 7);
            y.c = y.c ^ rl(y.b + y.a, 9);
            y.d = y.d ^ rl(y.c + y.b, 13);
            y.a = y.a ^ rl(y.d + y.c, 18);
        end
        return y;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = $countones(MASKS[g]) + 1;
        beat_t        q[$];
        logic         stalled = 1'b0;
        logic [127:0] hold_data;
        logic [3:0]   hold_tag;

        quarter_round_pipe #(
            .DATA_WIDTH (32),
            .TAG_WIDTH  (4),
            .REG_MASK   (MASKS[g])
        ) u_dut (
            .i_aclk    (aclk),
            .i_aresetn (aresetn),
            .i_valid   (i_valid),
            .o_ready   (o_ready[g]),
            .i_mode    (i_mode),
            .i_tag     (i_tag),
            .i_a       (i_a),
            .i_b       (i_b),
            .i_c       (i_c),
            .i_d       (i_d),
            .o_valid   (o_valid[g]),
            .i_ready   (i_ready),
            .o_tag     (o_tag[g]),
            .o_a       (o_a[g]),
            .o_b       (o_b[g]),
            .o_c       (o_c[g]),
            .o_d       (o_d[g]),
            .o_busy    (o_busy[g])
        );

        always @(negedge aclk) begin
            beat_t e;
            check_val($sformatf("busy%0d", g), o_busy[g], q.size() != 0);
            if (!aresetn) begin
                q.delete();
                stalled = 1'b0;
            end else begin
                check_val($sformatf("ready%0d", g), o_ready[g], !o_valid[g] | i_ready);
                if (stalled) begin
                    check_val($sformatf("hold_data%0d", g), {o_a[g], o_b[g], o_c[g], o_d[g]}, hold_data);
                    check_val($sformatf("hold_tag%0d", g), o_tag[g], hold_tag);
                end
                if (o_valid[g] && i_ready) begin
                    if (q.size() == 0) begin
                        check_val($sformatf("unexpected_beat%0d", g), o_valid[g], 1'b0);
                    end else begin
                        e = q.pop_front();
                        check_val($sformatf("tag%0d", g), o_tag[g], e.tag);
                        check_val($sformatf("data%0d", g), {o_a[g], o_b[g], o_c[g], o_d[g]},
                                  {e.a, e.b, e.c, e.d});
                        if (lat_chk) check_val($sformatf("latency%0d", g), cycle - e.cyc, LAT);
                    end
                end
                stalled   = o_valid[g] && !i_ready;
                hold_data = {o_a[g], o_b[g], o_c[g], o_d[g]};
                hold_tag  = o_tag[g];
                if (i_valid && o_ready[g]) begin
                    e.mode = i_mode; e.tag = i_tag;
                    e.a = i_a; e.b = i_b; e.c = i_c; e.d = i_d;
                    e = qr_model(e);
                    e.cyc = cycle;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic set_beat(input logic v, input logic m, input logic [3:0] t,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        i_valid = v; i_mode = m; i_tag = t;
        i_a = a; i_b = b; i_c = c; i_d = d;
    endtask

    task automatic set_random(input logic v);
        set_beat(v, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 $urandom, $urandom, $urandom, $urandom);
    endtask

    // Single beat into an idle pipe; each instance must show it exactly its latency later.
    task automatic send_vec(input logic m, input logic [3:0] t,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d,
                            input logic [127:0] exp, input string name);
        @(posedge aclk); #1;
        i_ready = 1'b1;
        set_beat(1'b1, m, t, a, b, c, d);
        @(posedge aclk); #1;
        i_valid = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge aclk);
            for (int g = 0; g < NDUT; g++) begin
                if (cyc == $countones(MASKS[g]) + 1) begin
                    check_val($sformatf("%s_valid%0d", name, g), o_valid[g], 1'b1);
                    check_val($sformatf("%s_tag%0d", name, g), o_tag[g], t);
                    check_val($sformatf("%s_data%0d", name, g),
                              {o_a[g], o_b[g], o_c[g], o_d[g]}, exp);
                end
            end
        end
    endtask

    task automatic drain();
        int left = 0;
        @(posedge aclk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            left = g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size();
            if (left == 0) break;
        end
        check_val("drain", left, 0);
    endtask

    initial begin
        beat_t m;

        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        for (int g = 0; g < NDUT; g++) begin
            check_val($sformatf("rst_valid%0d", g), o_valid[g], 1'b0);
            check_val($sformatf("rst_busy%0d", g), o_busy[g], 1'b0);
            check_val($sformatf("rst_ready%0d", g), o_ready[g], 1'b1);
            check_val($sformatf("rst_out%0d", g), {o_tag[g], o_a[g], o_b[g], o_c[g], o_d[g]}, '0);
        end

        // Directed vectors and boundaries, unstalled, with exact latency.
        lat_chk = 1'b1;
        send_vec(1'b0, 4'hA, 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567,
                 {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}, "chacha_vec");
        send_vec(1'b1, 4'h5, 32'h00000001, 32'h0, 32'h0, 32'h0,
                 {32'h08008145, 32'h00000080, 32'h00010200, 32'h20500000}, "salsa_vec");
        send_vec(1'b0, 4'h1, 32'h0, 32'h0, 32'h0, 32'h0, '0, "chacha_zero");
        send_vec(1'b1, 4'h2, 32'h0, 32'h0, 32'h0, 32'h0, '0, "salsa_zero");
        for (int md = 0; md < 2; md++) begin
            m.mode = 1'(md); m.tag = 4'hF;
            m.a = '1; m.b = '1; m.c = '1; m.d = '1;
            m = qr_model(m);
            send_vec(1'(md), 4'hF, '1, '1, '1, '1, {m.a, m.b, m.c, m.d},
                     md == 0 ? "chacha_ones" : "salsa_ones");
        end

        // Streaming: one beat per cycle, mixed modes.
        for (int i = 0; i < 64; i++) begin
            @(posedge aclk); #1;
            set_random(1'b1);
        end
        drain();
        lat_chk = 1'b0;

        // Backpressure with random gaps.
        for (int i = 0; i < 500; i++) begin
            @(posedge aclk); #1;
            i_ready = ($urandom_range(0, 2) != 0);
            set_random($urandom_range(0, 3) != 0);
        end
        drain();

        // Fill and stall, then reset for one cycle.
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk); #1;
            i_ready = 1'b0;
            set_random(1'b1);
        end
        @(posedge aclk); #1;
        i_valid = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        for (int g = 0; g < NDUT; g++) begin
            check_val($sformatf("mid_rst_valid%0d", g), o_valid[g], 1'b0);
            check_val($sformatf("mid_rst_busy%0d", g), o_busy[g], 1'b0);
            check_val($sformatf("mid_rst_out%0d", g), {o_tag[g], o_a[g], o_b[g], o_c[g], o_d[g]}, '0);
        end

        // Fresh traffic after reset.
        lat_chk = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge aclk); #1;
            set_random(1'b1);
        end
        drain();
        lat_chk = 1'b0;
        @(negedge aclk);
        for (int g = 0; g < NDUT; g++)
            check_val($sformatf("idle_busy%0d", g), o_busy[g], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
